// File: rtl/io_output_ctrl.sv
// Memory-mapped output-port controller: three latched ports with valid/ack handshake.
// Define IO_OUTPUT_READBACK_EN to let software read back the port registers.
module io_output_ctrl #(
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter logic [5:0]  ADDR_BASE   = 6'b110000
) (
    input  logic        io_clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        io_we,
    input  logic [31:0] wdata,
    output logic [31:0] io_read_data,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic [31:0] out_port2,
    output logic [2:0]  out_valid,
    input  logic [2:0]  out_ack
);

    logic [5:0]  word;
    logic [2:0]  port_hit;
    logic        stat_hit;
    logic [2:0]  port_wr;
    logic        stat_wr;
    logic [2:0]  ovr_clr;
    logic [2:0]  ovr_set;
    logic [2:0]  valid_d;
    logic [2:0]  ovr_d;

    logic [31:0] port_q [3];
    logic [2:0]  valid_q;
    logic [2:0]  ovr_q;

    assign word = addr[7:2];

    always_comb begin
        port_hit = '0;
        for (int i = 0; i < 3; i++) begin
            port_hit[i] = (word == ADDR_BASE + 6'(i));
        end
    end

    assign stat_hit = (word == ADDR_BASE + 6'd3);
    assign port_wr  = port_hit & {3{io_we}};
    assign stat_wr  = stat_hit & io_we;
    assign ovr_clr  = wdata[5:3] & {3{stat_wr}};

    // An ack in the same cycle consumes the old data, so only an unacked
    // overwrite of pending data counts as an overrun.
    assign ovr_set  = port_wr & valid_q & ~out_ack;
    assign valid_d  = port_wr | (valid_q & ~out_ack);
    assign ovr_d    = ovr_set | (ovr_q & ~ovr_clr);

    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                port_q[i] <= RESET_VALUE;
            end
            valid_q <= '0;
            ovr_q   <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (port_wr[i]) begin
                    port_q[i] <= wdata;
                end
            end
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_port0 = port_q[0];
    assign out_port1 = port_q[1];
    assign out_port2 = port_q[2];
    assign out_valid = valid_q;

    always_comb begin
        io_read_data = '0;
        if (stat_hit) begin
            io_read_data = {26'd0, ovr_q, valid_q};
        end
`ifdef IO_OUTPUT_READBACK_EN
        for (int i = 0; i < 3; i++) begin
            if (port_hit[i]) begin
                io_read_data = port_q[i];
            end
        end
`endif
    end

endmodule

// File: doc/io_output_ctrl.md
# io_output_ctrl

Memory-mapped output-port controller: the write-side counterpart of the CPU's input-port block. A CPU store to an output-port address latches data into one of three 32-bit output registers that drive external peripherals (LEDs, 7-segment drivers). Each port then raises a valid flag that the peripheral clears with an acknowledge. A status word records pending and overrun conditions per port. The block sits on the CPU data-memory bus beside the input-port block and shares its `addr[7:2]` word-select decoding.

## Interface
Parameters:
- `RESET_VALUE`, default `32'h0`: reset contents of `out_port0..2`.
- `ADDR_BASE`, default `6'b110000`: `addr[7:2]` of port 0 (byte `0xC0`).
  - Port 1 is `ADDR_BASE+1` (`0xC4`).
  - Port 2 is `ADDR_BASE+2` (`0xC8`).
  - Status is `ADDR_BASE+3` (`0xCC`).

Ports:
- `io_clk`, in, 1: sole clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `addr`, in, 32: CPU byte address; only `addr[7:2]` is decoded.
- `io_we`, in, 1: CPU write strobe, qualified by `addr`.
- `wdata`, in, 32: CPU store data.
- `io_read_data`, out, 32: combinational read data for the current `addr`.
- `out_port0`, `out_port1`, `out_port2`, out, 32 each: registered output data.
- `out_valid`, out, 3: bit i high while port i holds data not yet acknowledged.
- `out_ack`, in, 3: bit i is a peripheral acknowledge for port i; sampled on the edge.

## Operation
- Write decode: `io_we=1` with `addr[7:2]==ADDR_BASE+i` (i=0..2) is a port-i write.
  - On the edge, `out_port_i <= wdata` and `valid[i] <= 1`.
- Per-port handshake. Each port has 1-bit `valid[i]` and a sticky 1-bit `ovr[i]`. Per edge:
  - write only: `valid=1`. If `valid` was already 1, `ovr[i]<=1` (unconsumed data overwritten).
  - ack only: `valid<=0`. An ack with `valid=0` is ignored; no error.
  - write and ack in the same cycle: the ack consumes the old data and the write loads new data. `valid` stays 1, `ovr` is unchanged.
  - neither: hold.
- Status register (read at `ADDR_BASE+3`):
  - `[2:0]` = `valid`.
  - `[5:3]` = `ovr`.
  - `[31:6]` = 0.
- Status write: `io_we` at `ADDR_BASE+3` clears `ovr[i]` where `wdata[3+i]=1` (write-1-to-clear).
  - A clear and a new overrun on the same port in the same cycle: the overrun wins and `ovr` stays 1.
  - Status writes never affect `valid` or the port data.
- Reads are combinational from registered state: `io_read_data` returns status at `ADDR_BASE+3`, and 0 for every other address (subject to Configuration).
- Writes to any other address are ignored.
- `addr[1:0]` and `addr[31:8]` are ignored.

## Timing
- Reset (asynchronous, active-high):
  - `out_port0..2 = RESET_VALUE`.
  - `out_valid = 3'b000`, `ovr = 3'b000`.
  - `io_read_data` reflects the reset state, i.e. status = 0.
- Reset asserted mid-handshake drops `out_valid` immediately, without waiting for a clock. Pending data is discarded.
- Write latency: `out_port_i` and `out_valid[i]` change at the edge that samples `io_we`. They are visible one cycle after the store is issued, with zero additional cycles.
- `out_valid` is a direct register output with no combinational path from `out_ack`. An ack sampled at edge N makes `out_valid` low after edge N.
- `io_read_data` is purely combinational: same-cycle response to `addr`. It reflects state as of the last edge.
- `out_port_i` holds its value indefinitely. Ack does not change the data.

## Configuration
- `IO_OUTPUT_READBACK_EN` defined:
  - Reads at `ADDR_BASE+i` (i=0..2) return the current `out_port_i`, so software can read back the port value.
- `IO_OUTPUT_READBACK_EN` undefined:
  - Those addresses read 0.
  - The readback mux is not synthesized.
- Status readback at `ADDR_BASE+3` is present in both builds.

## Test plan
- Reset values: assert `reset` mid-cycle with no clock edge. Outputs must go immediately to `out_port0..2=0`, `out_valid=000`, and a status read at `0xCC` returns `0`.
- Basic handshake:
  - Write `0xDEADBEEF` to `0xC4`. On the next cycle `out_port1=0xDEADBEEF` and `out_valid=010`.
  - Pulse `out_ack=010`. `out_valid=000` after that edge and `out_port1` is unchanged.
- Overrun:
  - Write `0x1` to `0xC0`, then `0x2` to `0xC0` with no ack. Result: `out_port0=2`, status `=0x09`.
  - Write `0x08` to `0xCC`. Status `=0x01`.
- Simultaneous write and ack on port 2 while valid: write `0x55` to `0xC8` with `out_ack=100`. Result: `out_port2=0x55`, `out_valid[2]=1`, `ovr[2]=0`.
- Readback, both builds: after writing `0x1234` to `0xC8`, a read of `0xC8` returns `0x1234` with `IO_OUTPUT_READBACK_EN` defined and `0` without. A write to `0x80` changes no output.
- Reset mid-handshake: with `out_valid=111` and `ovr=001`, assert `reset` between edges. Immediately `out_valid=000`, status `0`, and ports return to `RESET_VALUE`.
